dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the MIPS core's load/store port and a secondary
//  DMA/host port (program/data loader, test harness). Fixed CPU priority with DMA anti-starvation
//  and bounded DMA bursts. Sits between core/DMA and datamem; stalls the core when it loses arbitration.
// PARAMETERS
//  AW          8  address width (matches core ALUOut / datamem DataAddr)
//  DW          8  data width
//  STARVE_MAX  4  consecutive denied DMA cycles before DMA is forced in over the CPU
//  BURST_MAX   8  max consecutive DMA beats under dma_lock before a forced CPU slot
// PORTS
//  clk          in   1   system clock (rising edge)
//  rst          in   1   asynchronous active-low reset (0 = reset)
//  cpu_req      in   1   core memory access this cycle (load or store)
//  cpu_we       in   1   core store (MemWrite)
//  cpu_addr     in   AW  core address
//  cpu_wdata    in   DW  core store data
//  cpu_rdata    out  DW  core load data (combinational from mem_rdata)
//  cpu_stall    out  1   core must hold PC/inst; = cpu_req & ~cpu granted
//  dma_req      in   1   DMA access request
//  dma_we       in   1   DMA write
//  dma_lock     in   1   request burst ownership
//  dma_addr     in   AW  DMA address
//  dma_wdata    in   DW  DMA write data
//  dma_gnt      out  1   DMA access performed this cycle (combinational)
//  dma_rvalid   out  1   registered: DMA read data valid (1 cycle after granted read)
//  dma_rdata    out  DW  registered DMA read data
//  mem_we       out  1   to datamem MemWrite
//  mem_addr     out  AW  to datamem DataAddr
//  mem_wdata    out  DW  to datamem DataIn
//  mem_rdata    in   DW  from datamem DataOut (async read)
// BEHAVIOUR
//  - One access per cycle. Grant is combinational from inputs + registered state; mux follows grant.
//  - No grant: mem_we=0, mem_addr=cpu_addr, mem_wdata=cpu_wdata. mem_we never 1 without a grant.
//  - FSM states ARB, BURST, YIELD:
//    ARB:   if cpu_req & starve_cnt<STARVE_MAX -> CPU; else if dma_req -> DMA.
//           DMA granted with dma_lock=1 -> BURST next, beat_cnt=1.
//    BURST: DMA granted while dma_req=1 (CPU stalled); beat_cnt++ per beat.
//           dma_req=0 or dma_lock=0 -> ARB next (no grant to DMA this cycle if dma_req=0; arbitrate as ARB).
//           beat_cnt==BURST_MAX after a beat -> YIELD next.
//    YIELD: DMA masked for exactly one cycle; CPU granted if cpu_req; -> ARB.
//  - starve_cnt: +1 when dma_req & ~dma_gnt, saturates at STARVE_MAX; clears on dma_gnt or dma_req=0.
//  - dma_rvalid<=dma_gnt & ~dma_we; dma_rdata<=mem_rdata on that edge, else holds.
//  - cpu_rdata=mem_rdata always; meaningful only when CPU granted.
//  - Simultaneous cpu_req & dma_req in ARB with starve_cnt<STARVE_MAX: CPU wins, starve_cnt++.
//  - Reset (async, any state incl. mid-burst): state=ARB, starve_cnt=0, beat_cnt=0,
//    dma_rvalid=0, dma_rdata=0; combinational outputs follow (mem_we=0 unless cpu_req&cpu_we).
//  - Counters are sized clog2(MAX+1); no wrap beyond saturation.
// STRUCTURE
//  - dmem_arb_pkg: state encoding (ARB/BURST/YIELD), grant-owner constants (OWN_NONE/CPU/DMA).
//  - One sub-module: sat_counter (parameterised width/max, inc/clr, saturating) used for
//    starve_cnt and beat_cnt. FSM, grant logic and mux flat in dmem_arbiter.
//  - Top integration: core MemWrite/ALUOut/rd2_Data -> cpu_*; cpu_stall gates PC update.
// TESTING (STARVE_MAX=4, BURST_MAX=8)
//  1 CPU only, store 0xA5 @0x10 -> same cycle mem_we=1 mem_addr=0x10 mem_wdata=0xA5, cpu_stall=0.
//  2 DMA only, read @0x20 holding 0x3C -> dma_gnt=1 cycle N; cycle N+1 dma_rvalid=1 dma_rdata=0x3C.
//  3 cpu_req & dma_req held, dma_lock=0 -> CPU 4 cycles, DMA 5th (cpu_stall=1 that cycle), repeats.
//  4 dma_lock=1, both held -> 8 DMA beats (cpu_stall=1), 1 YIELD cycle CPU granted, dma_gnt=0.
//  5 dma_req drops after 3 burst beats -> ARB next cycle, CPU granted immediately, beat_cnt=0.
//  6 rst=0 mid-burst (beat 5) -> immediately ARB, dma_rvalid=0, dma_rdata=0; no stray mem_we.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, grant owners
// and a helper that sizes saturating counters.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_BURST = 2'd1,
        ST_YIELD = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    // Bits needed to hold 0..max inclusive.
    function automatic int cnt_width(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU load/store port, the DMA/host port and the datamem port.
// slave = arbiter view, master = requesters + memory view.
interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          dma_req;
    logic          dma_we;
    logic          dma_lock;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port datamem arbiter: CPU has fixed priority, DMA gets anti-starvation
// slots and bounded locked bursts followed by one forced CPU (yield) cycle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int SW = cnt_width(STARVE_MAX);
    localparam int BW = cnt_width(BURST_MAX);

    arb_state_e    state_q, state_d;
    owner_e        owner;
    logic [SW-1:0] starve_q;
    logic [BW-1:0] beat_q;
    logic          cpu_gnt;
    logic          dma_gnt;
    logic          cpu_first;
    logic          dma_rvalid_q, dma_rvalid_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;

    // CPU keeps priority until the DMA has been denied STARVE_MAX times in a row.
    assign cpu_first = bus.cpu_req && (starve_q != SW'(STARVE_MAX));

    always_comb begin
        owner   = OWN_NONE;
        state_d = state_q;
        case (state_q)
            ST_ARB: begin
                if (cpu_first) begin
                    owner = OWN_CPU;
                end else if (bus.dma_req) begin
                    owner = OWN_DMA;
                end else if (bus.cpu_req) begin
                    owner = OWN_CPU;
                end
                if ((owner == OWN_DMA) && bus.dma_lock) begin
                    state_d = (BURST_MAX == 1) ? ST_YIELD : ST_BURST;
                end
            end
            ST_BURST: begin
                if (bus.dma_req) begin
                    owner = OWN_DMA;
                    if (!bus.dma_lock) begin
                        state_d = ST_ARB;
                    end else if (beat_q == BW'(BURST_MAX - 1)) begin
                        state_d = ST_YIELD;
                    end
                end else begin
                    owner   = bus.cpu_req ? OWN_CPU : OWN_NONE;
                    state_d = ST_ARB;
                end
            end
            ST_YIELD: begin
                owner   = bus.cpu_req ? OWN_CPU : OWN_NONE;
                state_d = ST_ARB;
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    assign cpu_gnt = (owner == OWN_CPU);
    assign dma_gnt = (owner == OWN_DMA);

    sat_counter #(.MAX(STARVE_MAX), .W(SW)) u_starve (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (bus.dma_req && !dma_gnt),
        .clr_i (dma_gnt || !bus.dma_req),
        .cnt_o (starve_q)
    );

    // beat count lives only while the next state is BURST, so ARB always sees zero.
    sat_counter #(.MAX(BURST_MAX), .W(BW)) u_beat (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (dma_gnt && (state_d == ST_BURST)),
        .clr_i (state_d != ST_BURST),
        .cnt_o (beat_q)
    );

    assign bus.mem_we    = dma_gnt ? bus.dma_we    : (cpu_gnt && bus.cpu_we);
    assign bus.mem_addr  = dma_gnt ? bus.dma_addr  : bus.cpu_addr;
    assign bus.mem_wdata = dma_gnt ? bus.dma_wdata : bus.cpu_wdata;

    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.cpu_stall = bus.cpu_req && !cpu_gnt;
    assign bus.dma_gnt   = dma_gnt;

    assign dma_rvalid_d = dma_gnt && !bus.dma_we;
    assign dma_rdata_d  = dma_rvalid_d ? bus.mem_rdata : dma_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign bus.dma_rvalid = dma_rvalid_q;
    assign bus.dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (STARVE_MAX=4, BURST_MAX=8) with a small datamem model.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   errs;
    int   checks;

    logic [7:0] mem [256];

    dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

    dmem_arbiter #(
        .AW(8), .DW(8), .STARVE_MAX(4), .BURST_MAX(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async-read, sync-write datamem.
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                         input logic dr, input logic dw, input logic dl,
                         input logic [7:0] da, input logic [7:0] dd);
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.dma_req   = dr;
        bus.dma_we    = dw;
        bus.dma_lock  = dl;
        bus.dma_addr  = da;
        bus.dma_wdata = dd;
    endtask

    initial begin
        logic exp_g;
        errs   = 0;
        checks = 0;
        rst    = 1'b0;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

        // Reset state
        #1;
        chk("rst_rvalid", bus.dma_rvalid, 1'b0);
        chk("rst_rdata",  bus.dma_rdata,  8'h00);
        chk("rst_mem_we", bus.mem_we,     1'b0);
        chk("rst_dma_gnt", bus.dma_gnt,   1'b0);
        drive(1, 1, 8'h44, 8'h11, 0, 0, 0, 8'h00, 8'h00);
        #1;
        chk("rst_cpu_we_passes", bus.mem_we, 1'b1);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // 1: CPU store 0xA5 @0x10
        @(negedge clk);
        drive(1, 1, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00);
        #1;
        chk("t1_mem_we",    bus.mem_we,    1'b1);
        chk("t1_mem_addr",  bus.mem_addr,  8'h10);
        chk("t1_mem_wdata", bus.mem_wdata, 8'hA5);
        chk("t1_cpu_stall", bus.cpu_stall, 1'b0);
        chk("t1_dma_gnt",   bus.dma_gnt,   1'b0);
        @(negedge clk);
        drive(1, 1, 8'h20, 8'h3C, 0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        drive(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        #1;
        chk("t1_cpu_rdata", bus.cpu_rdata, 8'hA5);
        chk("t1_load_we",   bus.mem_we,    1'b0);

        // 2: DMA-only read @0x20 (holds 0x3C)
        @(negedge clk);
        drive(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 8'h00);
        #1;
        chk("t2_dma_gnt",  bus.dma_gnt,    1'b1);
        chk("t2_mem_addr", bus.mem_addr,   8'h20);
        chk("t2_rv_early", bus.dma_rvalid, 1'b0);
        @(negedge clk);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        #1;
        chk("t2_rvalid", bus.dma_rvalid, 1'b1);
        chk("t2_rdata",  bus.dma_rdata,  8'h3C);
        @(negedge clk);
        #1;
        chk("t2_rvalid_drop", bus.dma_rvalid, 1'b0);
        chk("t2_rdata_hold",  bus.dma_rdata,  8'h3C);

        // 3: both requesting, no lock: 4 CPU then 1 DMA, repeating
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1, 0, 8'h01, 8'h00, 1, 1, 0, 8'h30, 8'h77);
            #1;
            exp_g = ((i % 5) == 4);
            chk($sformatf("t3_dma_gnt[%0d]", i),   bus.dma_gnt,   exp_g);
            chk($sformatf("t3_cpu_stall[%0d]", i), bus.cpu_stall, exp_g);
            chk($sformatf("t3_mem_addr[%0d]", i),  bus.mem_addr,  exp_g ? 8'h30 : 8'h01);
        end
        @(negedge clk);
        drive(1, 0, 8'h30, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        #1;
        chk("t3_dma_wrote", bus.cpu_rdata, 8'h77);

        // 4: locked burst: 4 CPU, 8 DMA beats, 1 yield to CPU, then CPU
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(1, 0, 8'h10, 8'h00, 1, 0, 1, 8'h20, 8'h00);
            #1;
            exp_g = (i >= 4) && (i <= 11);
            chk($sformatf("t4_dma_gnt[%0d]", i),   bus.dma_gnt,    exp_g);
            chk($sformatf("t4_cpu_stall[%0d]", i), bus.cpu_stall,  exp_g);
            chk($sformatf("t4_rvalid[%0d]", i),    bus.dma_rvalid, (i >= 5) && (i <= 12));
        end
        @(negedge clk);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

        // 5: burst aborted after 3 beats, CPU served at once; next burst is a full 8
        // 6 (tail): restart burst and hit reset at beat 5
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(i == 3, 0, 8'h10, 8'h00, i != 3, 0, 1, 8'h20, 8'h00);
            #1;
            exp_g = (i != 3) && (i != 12);
            chk($sformatf("t5_dma_gnt[%0d]", i), bus.dma_gnt, exp_g);
            if (i == 3) begin
                chk("t5_cpu_stall", bus.cpu_stall, 1'b0);
                chk("t5_mem_addr",  bus.mem_addr,  8'h10);
            end
        end
        @(posedge clk);
        #1;
        chk("t6_pre_rvalid", bus.dma_rvalid, 1'b1);
        chk("t6_pre_rdata",  bus.dma_rdata,  8'h3C);
        rst = 1'b0;
        drive(1, 0, 8'h10, 8'h00, 1, 0, 1, 8'h20, 8'h00);
        #1;
        chk("t6_rvalid",    bus.dma_rvalid, 1'b0);
        chk("t6_rdata",     bus.dma_rdata,  8'h00);
        chk("t6_cpu_stall", bus.cpu_stall,  1'b0);
        chk("t6_dma_gnt",   bus.dma_gnt,    1'b0);
        chk("t6_mem_we",    bus.mem_we,     1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        #1;
        chk("t6_after_we", bus.mem_we, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
